// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state encoding and kernel constants for the 5x5 convolution scheduler.
package conv_pkg;
    typedef enum logic [2:0] {IDLE, CFG, FRM_CLR, STREAM, DRAIN, NEXT, FIN} state_t;
    localparam int KERNEL_TAPS = 25;
    localparam int WIN_CLR_CYC = 2;
endpackage

// File: rtl/chan_loop_cnt.sv
// chan_loop_cnt: nested input/output channel counters with feature-map and weight base accumulators.
module chan_loop_cnt import conv_pkg::*; #(
    parameter int ADDR_W  = 11,
    parameter int CH_W    = 6,
    parameter int WADDR_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_init,
    input  logic               i_step,
    input  logic [CH_W-1:0]    i_in_ch,
    input  logic [CH_W-1:0]    i_out_ch,
    input  logic [ADDR_W-1:0]  i_fsz,
    output logic [CH_W-1:0]    o_ic,
    output logic [CH_W-1:0]    o_oc,
    output logic               o_ic_last,
    output logic               o_oc_last,
    output logic [ADDR_W-1:0]  o_fm_base,
    output logic [WADDR_W-1:0] o_wt_base
);
    assign o_ic_last = o_ic == i_in_ch - CH_W'(1);
    assign o_oc_last = o_oc == i_out_ch - CH_W'(1);

    // Weights are laid out kernel after kernel for the whole layer, so wt_base never rewinds.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_init) begin
            o_ic      <= '0;
            o_oc      <= '0;
            o_fm_base <= '0;
            o_wt_base <= '0;
        end else if (i_step) begin
            o_wt_base <= o_wt_base + WADDR_W'(KERNEL_TAPS);
            o_ic      <= o_ic_last ? '0 : o_ic + CH_W'(1);
            o_oc      <= o_ic_last ? o_oc + CH_W'(1) : o_oc;
            o_fm_base <= o_ic_last ? '0 : o_fm_base + i_fsz;
        end
    end
endmodule

// File: rtl/conv5x5_frame_sched.sv
// conv5x5_frame_sched: layer scheduler streaming one input-channel frame per (oc, ic) pair.
// Optional SCHED_PERF_CNT_EN adds busy-cycle and stream-stall performance counters.
module conv5x5_frame_sched import conv_pkg::*; #(
    parameter int ADDR_W    = 11,
    parameter int CH_W      = 6,
    parameter int WADDR_W   = 16,
    parameter int DRAIN_CYC = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [7:0]         i_hs_num,
    input  logic [7:0]         i_vs_num,
    input  logic               i_padding,
    input  logic [CH_W-1:0]    i_in_ch,
    input  logic [CH_W-1:0]    i_out_ch,
    input  logic               i_win_valid,
    output logic               o_win_clr,
    output logic               o_win_data_en,
    output logic [ADDR_W-1:0]  o_fm_base,
    output logic [WADDR_W-1:0] o_wt_base,
    output logic [CH_W-1:0]    o_ic_idx,
    output logic [CH_W-1:0]    o_oc_idx,
    output logic               o_acc_clr,
    output logic               o_acc_last,
    output logic               o_busy,
    output logic               o_done,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]        o_perf_cycles,
    output logic [31:0]        o_perf_stall,
`endif
    output logic               o_cfg_err
);
    state_t state, state_nx;
    logic [7:0]        hs, vs, hm, vm;
    logic              pad, accept, cfg_bad, win_hit, ic_last, oc_last;
    logic [CH_W-1:0]   in_ch, out_ch;
    logic [15:0]       win_exp, win_exp_c, win_cnt, cyc;
    logic [ADDR_W-1:0] fsz;

    assign accept  = state == IDLE && i_start;
    assign win_hit = i_win_valid && win_cnt + 16'd1 == win_exp;

    // Without padding the 5x5 window loses two pixels on each border.
    always_comb begin
        hm        = pad ? hs - 8'd4 : hs;
        vm        = pad ? vs - 8'd4 : vs;
        win_exp_c = {8'd0, hm} * {8'd0, vm};
        cfg_bad   = in_ch == '0 || out_ch == '0 || (pad && (hs < 8'd5 || vs < 8'd5)) || win_exp_c == '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        o_win_clr     = 1'b0;
        o_win_data_en = 1'b0;
        o_acc_clr     = 1'b0;
        o_acc_last    = 1'b0;
        o_busy        = state != IDLE && state != FIN;
        o_done        = 1'b0;
        case (state)
            IDLE:    state_nx = i_start ? CFG : IDLE;
            CFG:     state_nx = cfg_bad ? FIN : FRM_CLR;
            FRM_CLR: begin
                o_win_clr = 1'b1;
                state_nx  = cyc == 16'(WIN_CLR_CYC - 1) ? STREAM : FRM_CLR;
            end
            STREAM:  begin
                o_win_data_en = 1'b1;
                o_acc_clr     = o_ic_idx == '0;
                o_acc_last    = ic_last;
                state_nx      = win_hit ? DRAIN : STREAM;
            end
            DRAIN:   state_nx = cyc == 16'(DRAIN_CYC - 1) ? NEXT : DRAIN;
            NEXT:    state_nx = ic_last && oc_last ? FIN : FRM_CLR;
            FIN:     begin
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hs        <= '0;
            vs        <= '0;
            pad       <= 1'b0;
            in_ch     <= '0;
            out_ch    <= '0;
            win_exp   <= '0;
            fsz       <= '0;
            win_cnt   <= '0;
            cyc       <= '0;
            o_cfg_err <= 1'b0;
        end else begin
            cyc <= state_nx != state ? '0 : cyc + 16'd1;
            if (accept) begin
                hs        <= i_hs_num;
                vs        <= i_vs_num;
                pad       <= i_padding;
                in_ch     <= i_in_ch;
                out_ch    <= i_out_ch;
                o_cfg_err <= 1'b0;
            end
            if (state == CFG) begin
                win_exp <= win_exp_c;
                fsz     <= ADDR_W'({8'd0, hs} * {8'd0, vs});
                if (cfg_bad)
                    o_cfg_err <= 1'b1;
            end
            if (state == FRM_CLR)
                win_cnt <= '0;
            if (state == STREAM && i_win_valid)
                win_cnt <= win_cnt + 16'd1;
            // A window after the expected count means the generator overran the frame.
            if (state == DRAIN && i_win_valid)
                o_cfg_err <= 1'b1;
        end
    end

    chan_loop_cnt #(.ADDR_W(ADDR_W), .CH_W(CH_W), .WADDR_W(WADDR_W)) u_loop (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_init    (accept),
        .i_step    (state == NEXT),
        .i_in_ch   (in_ch),
        .i_out_ch  (out_ch),
        .i_fsz     (fsz),
        .o_ic      (o_ic_idx),
        .o_oc      (o_oc_idx),
        .o_ic_last (ic_last),
        .o_oc_last (oc_last),
        .o_fm_base (o_fm_base),
        .o_wt_base (o_wt_base)
    );

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || accept) begin
            o_perf_cycles <= '0;
            o_perf_stall  <= '0;
        end else begin
            if (o_busy && ~&o_perf_cycles)
                o_perf_cycles <= o_perf_cycles + 32'd1;
            if (state == STREAM && !i_win_valid && ~&o_perf_stall)
                o_perf_stall <= o_perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_conv5x5_frame_sched.sv
// tb_conv5x5_frame_sched: directed bench for the 5x5 frame scheduler with a per-frame monitor.
module tb_conv5x5_frame_sched;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, pad = 1'b0, inj_v = 1'b0;
    logic [7:0]  hs = 8'd8, vs = 8'd8;
    logic [5:0]  in_ch = 6'd1, out_ch = 6'd1;
    logic        win_valid, win_clr, win_data_en, acc_clr, acc_last, busy, done, cfg_err;
    logic [10:0] fm_base;
    logic [15:0] wt_base;
    logic [5:0]  ic_idx, oc_idx;

    int n_tests = 0, n_fail = 0;
    int nfr, nen, nclr, ndone, lat;
    int fr_len[8], fr_fm[8], fr_wt[8], fr_ic[8], fr_oc[8], fr_aclr[8], fr_alast[8];
    logic prev_en = 1'b0;

    // The window generator model answers every STREAM cycle with a valid window.
    assign win_valid = win_data_en | inj_v;

    conv5x5_frame_sched dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_hs_num      (hs),
        .i_vs_num      (vs),
        .i_padding     (pad),
        .i_in_ch       (in_ch),
        .i_out_ch      (out_ch),
        .i_win_valid   (win_valid),
        .o_win_clr     (win_clr),
        .o_win_data_en (win_data_en),
        .o_fm_base     (fm_base),
        .o_wt_base     (wt_base),
        .o_ic_idx      (ic_idx),
        .o_oc_idx      (oc_idx),
        .o_acc_clr     (acc_clr),
        .o_acc_last    (acc_last),
        .o_busy        (busy),
        .o_done        (done),
        .o_cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (win_data_en && !prev_en && nfr < 8) begin
            fr_fm[nfr]    = int'(fm_base);
            fr_wt[nfr]    = int'(wt_base);
            fr_ic[nfr]    = int'(ic_idx);
            fr_oc[nfr]    = int'(oc_idx);
            fr_aclr[nfr]  = int'(acc_clr);
            fr_alast[nfr] = int'(acc_last);
            fr_len[nfr]   = 0;
            nfr++;
        end
        if (win_data_en && win_valid && nfr > 0) fr_len[nfr-1]++;
        if (win_data_en) nen++;
        if (win_clr) nclr++;
        if (done) ndone++;
        prev_en = win_data_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        nfr = 0; nen = 0; nclr = 0; ndone = 0;
    endtask

    task automatic run(input int h, input int v, input int p, input int ic, input int oc,
                       input int poke, input int inj);
        hs = 8'(h); vs = 8'(v); pad = p[0]; in_ch = 6'(ic); out_ch = 6'(oc);
        clear_mon();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 5000) begin
            start = lat == poke;
            inj_v = lat == inj;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        inj_v = 1'b0;
        check("done_seen", done, 1);
        @(negedge clk);
    endtask

    task automatic check_two_frames(input string tag);
        check({tag, "_nfr"}, nfr, 2);
        check({tag, "_len0"}, fr_len[0], 64);
        check({tag, "_len1"}, fr_len[1], 64);
        check({tag, "_fm0"}, fr_fm[0], 0);
        check({tag, "_fm1"}, fr_fm[1], 64);
        check({tag, "_wt0"}, fr_wt[0], 0);
        check({tag, "_wt1"}, fr_wt[1], 25);
        check({tag, "_ic1"}, fr_ic[1], 1);
        check({tag, "_oc1"}, fr_oc[1], 0);
        check({tag, "_aclr0"}, fr_aclr[0], 1);
        check({tag, "_aclr1"}, fr_aclr[1], 0);
        check({tag, "_alast0"}, fr_alast[0], 0);
        check({tag, "_alast1"}, fr_alast[1], 1);
        check({tag, "_ndone"}, ndone, 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        clear_mon();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", win_data_en, 0);
        check("rst_clr", win_clr, 0);
        check("rst_fm", fm_base, 0);
        check("rst_wt", wt_base, 0);
        check("rst_err", cfg_err, 0);

        run(8, 8, 0, 2, 1, 0, 0);
        check_two_frames("pad2");
        check("pad2_nclr", nclr, 4);
        check("pad2_err", cfg_err, 0);

        run(8, 8, 0, 2, 1, 20, 0);
        check_two_frames("poke");

        run(8, 8, 0, 2, 1, 0, 70);
        check_two_frames("ovr");
        check("ovr_err", cfg_err, 1);

        run(8, 8, 1, 1, 3, 0, 0);
        check("nopad_err_clr", cfg_err, 0);
        check("nopad_nfr", nfr, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("nopad_len%0d", i), fr_len[i], 16);
            check($sformatf("nopad_fm%0d", i), fr_fm[i], 0);
            check($sformatf("nopad_wt%0d", i), fr_wt[i], 25 * i);
            check($sformatf("nopad_oc%0d", i), fr_oc[i], i);
            check($sformatf("nopad_aclr%0d", i), fr_aclr[i], 1);
            check($sformatf("nopad_alast%0d", i), fr_alast[i], 1);
        end
        check("nopad_ndone", ndone, 1);

        run(4, 8, 1, 1, 1, 0, 0);
        check("bad_lat", lat <= 3, 1);
        check("bad_err", cfg_err, 1);
        check("bad_en", nen, 0);
        check("bad_ndone", ndone, 1);

        hs = 8'd8; vs = 8'd8; pad = 1'b0; in_ch = 6'd2; out_ch = 6'd1;
        clear_mon();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (nfr < 2 && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        check("abort_reach", nfr, 2);
        check("abort_in_stream", win_data_en, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_en", win_data_en, 0);
        check("abort_fm", fm_base, 0);
        check("abort_wt", wt_base, 0);
        check("abort_ic", ic_idx, 0);
        check("abort_aclr", acc_clr, 0);
        check("abort_err", cfg_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ndone", ndone, 0);
        run(8, 8, 0, 2, 1, 0, 0);
        check_two_frames("rerun");
        check("rerun_ic0", fr_ic[0], 0);
        check("rerun_oc0", fr_oc[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
